fir_mac_sequencer: RTL

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_sample_shift_reg.sv | 22 ++
 rtl/fir_mac_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared tap geometry, coefficient format and sequencer state encoding
package fir_pkg;

  localparam int TAPS       = 8;
  localparam int TAP_ADDR_W = 3;
  localparam int COEF_FRAC  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } fir_state_t;

endpackage

// File: rtl/fir_sample_shift_reg.sv
// rtl/fir_sample_shift_reg.sv - 8-tap sample delay line, newest sample in the low slice
module fir_sample_shift_reg
  import fir_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic [DATA_W-1:0]        din,
  output logic [TAPS*DATA_W-1:0]   taps
);

  always_ff @(posedge clk) begin
    if (clr) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {taps[(TAPS-1)*DATA_W-1:0], din};
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - serial 8-tap FIR MAC sequencer; FIR_SATURATE_EN selects clamping over wrap
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     din,
  output logic [TAP_ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0]     coef_data,
  output logic                  coef_lock,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     dout
);

  localparam int PROD_W = DATA_W + COEF_W;

  fir_state_t state, state_nxt;

  logic [TAP_ADDR_W-1:0]     k;
  logic [TAPS*DATA_W-1:0]    taps;
  logic signed [DATA_W-1:0]  x_k;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  result;
  logic                      accept;

  assign in_ready  = (state == IDLE);
  assign coef_lock = (state == PRIME) || (state == MAC);
  assign accept    = in_valid && in_ready;

  fir_sample_shift_reg #(.DATA_W(DATA_W)) u_delay (
    .clk      (clk),
    .clr      (!rst_n),
    .shift_en (accept),
    .din      (din),
    .taps     (taps)
  );

  // coef_data lags coef_addr by one edge, so in MAC it always matches tap k
  assign x_k     = $signed(taps[k*DATA_W +: DATA_W]);
  assign prod    = $signed(coef_data) * x_k;
  assign acc_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted = acc_sum >>> COEF_FRAC;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (shifted > SAT_MAX) begin
      result = DATA_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      result = DATA_W'(SAT_MIN);
    end else begin
      result = DATA_W'(shifted);
    end
  end
`else
  assign result = DATA_W'(shifted);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PRIME;
      PRIME:   state_nxt = MAC;
      MAC:     if (k == TAP_ADDR_W'(TAPS - 1)) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k         <= '0;
      acc       <= '0;
      coef_addr <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            coef_addr <= '0;
            acc       <= '0;
          end
        end
        PRIME: begin
          coef_addr <= TAP_ADDR_W'(1);
          k         <= '0;
        end
        MAC: begin
          acc       <= acc_sum;
          k         <= k + TAP_ADDR_W'(1);
          // prefetch two ahead to cover memory latency; park on the last tap
          coef_addr <= (k < TAP_ADDR_W'(TAPS - 2)) ? k + TAP_ADDR_W'(2) : TAP_ADDR_W'(TAPS - 1);
          if (k == TAP_ADDR_W'(TAPS - 1)) begin
            dout      <= result;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
